// File: rtl/cmos_pattern_gen_if.sv
// cmos_pattern_gen_if: camera-side output bundle of the pattern generator
interface cmos_pattern_gen_if #(
    parameter int DATA_W = 8
);
    logic              cmos_pclk;
    logic              cmos_vsync;
    logic              cmos_href;
    logic [DATA_W-1:0] cmos_data;
    logic              frame_start;
    logic [15:0]       frame_cnt;

    modport master (
        output cmos_pclk, cmos_vsync, cmos_href, cmos_data, frame_start, frame_cnt
    );

    modport slave (
        input cmos_pclk, cmos_vsync, cmos_href, cmos_data, frame_start, frame_cnt
    );
endinterface

// File: rtl/cmos_pattern_gen.sv
// cmos_pattern_gen: CMOS-sensor-style timing and test pattern source
module cmos_pattern_gen #(
    parameter int DATA_W    = 8,
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_SYNC    = 5,
    parameter int H_BACK    = 5,
    parameter int H_FRONT   = 5,
    parameter int V_SYNC    = 1,
    parameter int V_BACK    = 0,
    parameter int V_FRONT   = 1,
    parameter int BPP       = 1,
    parameter int VSYNC_POL = 1
) (
    input  logic                cmos_xclk,
    input  logic                rst,
    input  logic                en,
    input  logic [2:0]          pat_sel,
    cmos_pattern_gen_if.master  cam
);
    localparam int H_TOTAL = H_SYNC + H_BACK + IMG_HDISP * BPP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;
    localparam int PW      = DATA_W * BPP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_A0   = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_A1   = HW'(H_SYNC + H_BACK + IMG_HDISP * BPP);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_S    = VW'(V_SYNC);
    localparam logic [VW-1:0] V_A0   = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_A1   = VW'(V_SYNC + V_BACK + IMG_VDISP);

    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [2:0]        pat_q, pat_d;
    logic              href_q, href_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vsync_q, vsync_d;
    logic              fs_q, fs_d;
    logic [15:0]       fc_q, fc_d;

    logic              h_end, v_end, active, b;
    logic [HW-1:0]     o;
    logic [31:0]       x, y, bar;
    logic [PW-1:0]     p;
    logic [DATA_W-1:0] pix;

    // pixel generation from the current position, plus next-state for timing and outputs
    always_comb begin
        h_end   = hcnt_q == H_LAST;
        v_end   = vcnt_q == V_LAST;
        active  = vcnt_q >= V_A0 && vcnt_q < V_A1 && hcnt_q >= H_A0 && hcnt_q < H_A1;
        o       = hcnt_q - H_A0;
        x       = BPP == 2 ? 32'(o >> 1) : 32'(o);
        b       = BPP == 2 ? o[0] : 1'b0;
        y       = 32'(vcnt_q) - 32'(V_A0);
        bar     = x * 32'd8 / 32'(IMG_HDISP);
        p       = pat_q == 3'd0 ? PW'(x) :
                  pat_q == 3'd1 ? PW'(y) :
                  pat_q == 3'd2 ? PW'(bar) << (PW - 3) :
                  pat_q == 3'd3 ? {PW{x[3] ^ y[3]}} :
                  pat_q == 3'd4 ? PW'(x + y + 32'(fc_q)) : '0;
        pix     = b ? p[DATA_W-1:0] : p[PW-1 -: DATA_W];
        hcnt_d  = !en ? hcnt_q : h_end ? '0 : hcnt_q + HW'(1);
        vcnt_d  = !(en && h_end) ? vcnt_q : v_end ? '0 : vcnt_q + VW'(1);
        pat_d   = (en && hcnt_q == '0 && vcnt_q == '0) ? pat_sel : pat_q;
        vsync_d = en ? vcnt_q >= V_S : vsync_q;
        href_d  = en ? active : href_q;
        data_d  = !en ? data_q : active ? pix : '0;
        fs_d    = en && h_end && v_end;
        fc_d    = fc_q + 16'(fs_d);
    end

    // state and registered outputs, cleared asynchronously so a frame is abandoned on reset
    always_ff @(posedge cmos_xclk or posedge rst) begin
        if (rst) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            pat_q   <= '0;
            href_q  <= 1'b0;
            data_q  <= '0;
            vsync_q <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            pat_q   <= pat_d;
            href_q  <= href_d;
            data_q  <= data_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign cam.cmos_pclk   = ~cmos_xclk;
    assign cam.cmos_vsync  = (VSYNC_POL != 0) ? vsync_q : ~vsync_q;
    assign cam.cmos_href   = href_q;
    assign cam.cmos_data   = data_q;
    assign cam.frame_start = fs_q;
    assign cam.frame_cnt   = fc_q;
endmodule

// File: tb/tb_cmos_pattern_gen.sv
// tb_cmos_pattern_gen: directed checks of timing, patterns, enable hold and async reset
module tb_cmos_pattern_gen;
    logic       clk = 0, rst = 0, en = 0;
    logic [2:0] pat_sel = 0;
    int total = 0, bad = 0, k = 0, mh = 0, mv = 0, mpat = 0, hcnt_hi = 0;
    int e_vs = 0, e_href = 0, e_data = 0, e_fs = 0, e_fc = 0;

    always #5 clk = ~clk;

    cmos_pattern_gen_if #(.DATA_W(8)) ifa ();
    cmos_pattern_gen_if #(.DATA_W(8)) ifb ();
    cmos_pattern_gen_if #(.DATA_W(8)) ifc ();

    cmos_pattern_gen #(.DATA_W(8), .IMG_HDISP(4), .IMG_VDISP(2), .H_SYNC(1), .H_BACK(1), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(0), .V_FRONT(1), .BPP(1), .VSYNC_POL(1))
        dut_a (.cmos_xclk(clk), .rst(rst), .en(en), .pat_sel(pat_sel), .cam(ifa));

    cmos_pattern_gen #(.DATA_W(8), .IMG_HDISP(16), .IMG_VDISP(2), .H_SYNC(1), .H_BACK(1), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(0), .V_FRONT(1), .BPP(1), .VSYNC_POL(0))
        dut_b (.cmos_xclk(clk), .rst(rst), .en(en), .pat_sel(3'd3), .cam(ifb));

    cmos_pattern_gen #(.DATA_W(8), .IMG_HDISP(4), .IMG_VDISP(2), .H_SYNC(1), .H_BACK(1), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(0), .V_FRONT(1), .BPP(2), .VSYNC_POL(1))
        dut_c (.cmos_xclk(clk), .rst(rst), .en(en), .pat_sel(3'd0), .cam(ifc));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mpat = 0; k = 0;
        e_vs = 0; e_href = 0; e_data = 0; e_fs = 0; e_fc = 0;
    endtask

    task automatic cyc();
        logic       en_s;
        logic [2:0] ps_s;
        en_s = en;
        ps_s = pat_sel;
        @(posedge clk);
        #1;
        k++;
        if (en_s) begin
            e_vs   = int'(mv >= 1);
            e_href = int'(mv >= 1 && mv <= 2 && mh >= 2 && mh <= 5);
            e_data = e_href == 0 ? 0 : mpat == 0 ? mh - 2 : mpat == 1 ? mv - 1 : 0;
            e_fs   = int'(mh == 6 && mv == 3);
            e_fc   = (e_fc + e_fs) & 32'hFFFF;
            if (mh == 0 && mv == 0) mpat = int'(ps_s);
            if (mh == 6) begin
                mh = 0;
                mv = (mv + 1) % 4;
            end else mh++;
        end else e_fs = 0;
        chk("a_vsync", int'(ifa.cmos_vsync), e_vs);
        chk("a_href", int'(ifa.cmos_href), e_href);
        chk("a_data", int'(ifa.cmos_data), e_data);
        chk("a_frame_start", int'(ifa.frame_start), e_fs);
        chk("a_frame_cnt", int'(ifa.frame_cnt), e_fc);
        if (ifa.cmos_href) hcnt_hi++;
        if (k == 13 || k == 22) chk("c_href_edge", int'(ifc.cmos_href), 0);
        if (k >= 14 && k <= 21) begin
            chk("c_href", int'(ifc.cmos_href), 1);
            chk("c_data", int'(ifc.cmos_data), ((k - 14) % 2 != 0) ? (k - 14) / 2 : 0);
        end
        if (k == 19) chk("b_vsync_inv_lo", int'(ifb.cmos_vsync), 1);
        if (k == 20) chk("b_vsync_inv_hi", int'(ifb.cmos_vsync), 0);
        if (k == 21 || k == 38) chk("b_href_edge", int'(ifb.cmos_href), 0);
        if (k >= 22 && k <= 37) begin
            chk("b_href", int'(ifb.cmos_href), 1);
            chk("b_data", int'(ifb.cmos_data), k < 30 ? 0 : 'hFF);
        end
    endtask

    initial begin
        #1 rst = 1;
        #1;
        chk("rst_href", int'(ifa.cmos_href), 0);
        chk("rst_data", int'(ifa.cmos_data), 0);
        chk("rst_vsync", int'(ifa.cmos_vsync), 0);
        chk("rst_fs", int'(ifa.frame_start), 0);
        chk("rst_fc", int'(ifa.frame_cnt), 0);
        chk("rst_b_vsync_inv", int'(ifb.cmos_vsync), 1);
        chk("pclk_low_phase", int'(ifa.cmos_pclk), int'(!clk));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        en = 1;
        model_reset();
        repeat (5) cyc();
        pat_sel = 1;
        repeat (35) cyc();
        pat_sel = 0;
        repeat (16) cyc();
        hcnt_hi = 0;
        repeat (11) cyc();
        en = 0;
        repeat (3) cyc();
        en = 1;
        repeat (3) cyc();
        chk("line_href_cycles", hcnt_hi, 7);
        repeat (14) cyc();
        for (int i = 0; i < 40; i++) begin
            if (e_href != 0 && e_data != 0) break;
            cyc();
        end
        chk("pre_rst_href", int'(ifa.cmos_href), 1);
        chk("pre_rst_fc", int'(ifa.frame_cnt), 3);
        #2;
        rst = 1;
        #1;
        chk("async_rst_href", int'(ifa.cmos_href), 0);
        chk("async_rst_data", int'(ifa.cmos_data), 0);
        chk("async_rst_fc", int'(ifa.frame_cnt), 0);
        chk("async_rst_vsync", int'(ifa.cmos_vsync), 0);
        chk("pclk_high_phase", int'(ifa.cmos_pclk), int'(!clk));
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        k = 100;
        repeat (30) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmos_pattern_gen.md
CMOS_PATTERN_GEN -- requirements
Module: cmos_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning output data bus width in bits.
REQ-002 SHALL have parameter IMG_HDISP, default 640, meaning active pixels per line.
REQ-003 SHALL have parameter IMG_VDISP, default 480, meaning active lines per frame.
REQ-004 SHALL have parameters H_SYNC/H_BACK/H_FRONT, default 5/5/5, meaning horizontal blanking in clocks; H_SYNC >= 1.
REQ-005 SHALL have parameters V_SYNC/V_BACK/V_FRONT, default 1/0/1, meaning vertical blanking in lines; V_SYNC >= 1.
REQ-006 SHALL have parameter BPP, default 1 (legal 1 or 2), meaning bytes (DATA_W words) per pixel.
REQ-007 SHALL have parameter VSYNC_POL, default 1, meaning 1 = vsync high during valid frame, 0 = inverted.
REQ-008 SHALL have port cmos_xclk  input  1  the single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-010 SHALL have port en  input  1  advance enable; timing freezes while low.
REQ-011 SHALL have port pat_sel  input  3  test pattern select.
REQ-012 SHALL have port cmos_pclk  output  1  equal to ~cmos_xclk (combinational).
REQ-013 SHALL have port cmos_vsync  output  1  frame sync, polarity per VSYNC_POL.
REQ-014 SHALL have port cmos_href  output  1  line-valid, high during active pixels.
REQ-015 SHALL have port cmos_data  output  DATA_W  pixel data, 0 outside active region.
REQ-016 SHALL have port frame_start  output  1  one-cycle pulse at each frame wrap.
REQ-017 SHALL have port frame_cnt  output  16  completed-frame count, wraps 0xFFFF -> 0.

Function
REQ-018 SHALL define H_TOTAL = H_SYNC+H_BACK+IMG_HDISP*BPP+H_FRONT and V_TOTAL = V_SYNC+V_BACK+IMG_VDISP+V_FRONT.
REQ-019 SHALL keep hcnt 0..H_TOTAL-1 incrementing when en=1, wrapping to 0; vcnt 0..V_TOTAL-1 increments (wrapping) when en=1 and hcnt=H_TOTAL-1.
REQ-020 SHALL hold hcnt, vcnt, cmos_href, cmos_data, cmos_vsync, frame_cnt unchanged while en=0, with frame_start forced 0.
REQ-021 SHALL register all outputs except cmos_pclk: values derived from the current (hcnt,vcnt) appear one clock later.
REQ-022 SHALL drive internal vsync_r = 0 when vcnt < V_SYNC, else 1; cmos_vsync = vsync_r if VSYNC_POL=1, else ~vsync_r.
REQ-023 SHALL mark active when V_SYNC+V_BACK <= vcnt < V_SYNC+V_BACK+IMG_VDISP and H_SYNC+H_BACK <= hcnt < H_SYNC+H_BACK+IMG_HDISP*BPP; cmos_href = active.
REQ-024 SHALL compute within active: o = hcnt-H_SYNC-H_BACK, x = o/BPP, b = o mod BPP, y = vcnt-V_SYNC-V_BACK.
REQ-025 SHALL form pixel value P of width DATA_W*BPP (all arithmetic truncated modulo 2^(DATA_W*BPP)) from latched pattern pat_q:
  0: P = x (horizontal ramp)
  1: P = y (vertical ramp)
  2: P = (x*8/IMG_HDISP) << (DATA_W*BPP-3) (8 colour bars)
  3: P = all ones if x[3]^y[3], else 0 (8x8 checkerboard)
  4: P = x + y + frame_cnt (moving ramp)
  5-7: P = 0
REQ-026 SHALL output byte b of P most-significant DATA_W word first (b=0 -> P[DATA_W*BPP-1 -: DATA_W]); cmos_data = 0 when not active.
REQ-027 SHALL load pat_q from pat_sel only when en=1, hcnt=0, vcnt=0; pat_sel changes mid-frame take effect the next frame.
REQ-028 SHALL assert frame_start and increment frame_cnt on the clock where en=1, hcnt=H_TOTAL-1, vcnt=V_TOTAL-1; no pulse for the first frame after reset.

Reset
REQ-029 SHALL, while rst=1, immediately force hcnt=vcnt=0, pat_q=0, cmos_href=0, cmos_data=0, vsync_r=0, frame_start=0, frame_cnt=0, regardless of clock.
REQ-030 SHALL, on rst asserted mid-line/mid-frame, abandon the frame; after release timing restarts from (0,0) with frame_cnt=0.

Verification (params DATA_W=8, IMG_HDISP=4, IMG_VDISP=2, H_*=1, V_SYNC=1, V_BACK=0, V_FRONT=1, BPP=1 unless stated: H_TOTAL=7, V_TOTAL=4)
REQ-031 SHALL cover reset/pattern 0, en=1: vsync low 7 cycles then high 21; href high 4 cycles on each of 2 lines with data 0x00,0x01,0x02,0x03; frame_start every 28 cycles; frame_cnt 0->1.
REQ-032 SHALL cover pattern 1: line 0 data 0x00 x4, line 1 data 0x01 x4.
REQ-033 SHALL cover pattern 3 with IMG_HDISP=16: line 0 data 0x00 for x=0..7, 0xFF for x=8..15.
REQ-034 SHALL cover BPP=2, pattern 0: href high 8 cycles/line, data 00,00,00,01,00,02,00,03.
REQ-035 SHALL cover en low 3 cycles mid-line: href/data hold, line stretches to 10 cycles; pat_sel 0->1 mid-frame changes data only from next frame.
REQ-036 SHALL cover rst pulse mid-href: href and data drop to 0 without clock edge; frame_cnt returns to 0.
